// File: rtl/spi_slave_xcvr_if.sv
// SPI pin and word-handshake bundle for spi_slave_xcvr.
// slave modport is the transceiver's view; master modport is the driving side.
interface spi_slave_xcvr_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  overrun;
  logic                  frame_err;

  modport slave (
    input  sclk, cs, mosi, tx_data, tx_valid, rx_ready,
    output miso, tx_ready, rx_data, rx_valid, overrun, frame_err
  );

  modport master (
    output sclk, cs, mosi, tx_data, tx_valid, rx_ready,
    input  miso, tx_ready, rx_data, rx_valid, overrun, frame_err
  );
endinterface

// File: rtl/spi_slave_xcvr.sv
// Full-duplex SPI slave, oversampled in the i_clk domain, all CPOL/CPHA modes.
// Define SPI_SLAVE_XCVR_FRAME_ERR_EN to enable the frame_err pulse.
module spi_slave_xcvr #(
  parameter int DATA_WIDTH  = 12,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit LSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  spi_slave_xcvr_if.slave    io_spi
);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    WAIT_HIGH,
    IDLE,
    ACTIVE
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                    r_sclk_d, r_cs_d;
  logic                    w_sclk, w_cs, w_mosi;
  logic                    w_lead, w_trail, w_cs_fall, w_cs_rise;
  logic                    w_act, w_sample, w_shift, w_last, w_done, w_load;
  logic [CW-1:0]           r_bit_cnt;
  logic [DATA_WIDTH-1:0]   r_rx_shift, w_rx_next, r_rx_data;
  logic [DATA_WIDTH-1:0]   r_tx_shift, w_tx_shifted;
  logic                    w_tx_bit;
  logic                    r_rx_valid, r_overrun, r_tx_ready, r_miso;

  // Synchronisers and edge-detect flops are left unreset so they keep
  // tracking the pins through reset and produce no false edges on release.
  always_ff @(posedge i_clk) begin
    r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], io_spi.sclk};
    r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   io_spi.cs};
    r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], io_spi.mosi};
    r_sclk_d    <= w_sclk;
    r_cs_d      <= w_cs;
  end

  assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];

  assign w_lead    = (r_sclk_d == CPOL) && (w_sclk != CPOL);
  assign w_trail   = (r_sclk_d != CPOL) && (w_sclk == CPOL);
  assign w_cs_fall = r_cs_d & ~w_cs;
  assign w_cs_rise = ~r_cs_d & w_cs;

  // cs rising wins over any sclk edge seen in the same cycle
  assign w_act     = (r_state == ACTIVE) && !w_cs_rise;
  assign w_sample  = w_act && (CPHA ? w_trail : w_lead);
  assign w_shift   = w_act && (CPHA ? w_lead : w_trail);
  assign w_last    = (r_bit_cnt == CW'(DATA_WIDTH - 1));
  assign w_done    = w_sample && w_last;

  // A shift edge with bit_cnt==0 is always a word start: for CPHA=1 it is the
  // first edge of a word, for CPHA=0 it follows the previous word's last sample.
  assign w_load    = ((r_state == IDLE) && w_cs_fall && !CPHA) ||
                     (w_shift && (r_bit_cnt == '0));

  always_comb begin
    if (LSB_FIRST) begin
      w_rx_next    = {w_mosi, r_rx_shift[DATA_WIDTH-1:1]};
      w_tx_shifted = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
      w_tx_bit     = r_tx_shift[0];
    end else begin
      w_rx_next    = {r_rx_shift[DATA_WIDTH-2:0], w_mosi};
      w_tx_shifted = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
      w_tx_bit     = r_tx_shift[DATA_WIDTH-1];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_HIGH: if (w_cs)      w_state_nxt = IDLE;
      IDLE:      if (w_cs_fall) w_state_nxt = ACTIVE;
      ACTIVE:    if (w_cs_rise) w_state_nxt = IDLE;
      default:                  w_state_nxt = WAIT_HIGH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= WAIT_HIGH;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_ready <= 1'b0;
      r_miso     <= 1'b0;
    end else begin
      r_overrun  <= 1'b0;
      r_tx_ready <= 1'b0;

      if (w_cs_rise) begin
        r_bit_cnt <= '0;
      end else if (w_sample) begin
        r_rx_shift <= w_rx_next;
        r_bit_cnt  <= w_last ? '0 : r_bit_cnt + 1'b1;
      end

      // A word landing on a handshake cycle replaces the one being consumed.
      if (w_done) begin
        if (!r_rx_valid || io_spi.rx_ready) begin
          r_rx_data  <= w_rx_next;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun  <= 1'b1;
        end
      end else if (r_rx_valid && io_spi.rx_ready) begin
        r_rx_valid <= 1'b0;
      end

      if (w_load) begin
        r_tx_shift <= io_spi.tx_valid ? io_spi.tx_data : '0;
        r_tx_ready <= io_spi.tx_valid;
      end else if (w_shift) begin
        r_tx_shift <= w_tx_shifted;
      end

      r_miso <= (r_state == ACTIVE) && w_tx_bit;
    end
  end

  assign io_spi.miso     = r_miso;
  assign io_spi.tx_ready = r_tx_ready;
  assign io_spi.rx_data  = r_rx_data;
  assign io_spi.rx_valid = r_rx_valid;
  assign io_spi.overrun  = r_overrun;

`ifdef SPI_SLAVE_XCVR_FRAME_ERR_EN
  logic r_frame_err;

  // Partial word at cs rise, or a cs fall before a clean cs-high was seen.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_frame_err <= 1'b0;
    else       r_frame_err <= ((r_state == ACTIVE) && w_cs_rise && (r_bit_cnt != '0)) ||
                              ((r_state == WAIT_HIGH) && w_cs_fall);
  end

  assign io_spi.frame_err = r_frame_err;
`else
  assign io_spi.frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_xcvr.sv
// Bench: one 12-bit mode-0 LSB-first slave plus four 8-bit MSB-first slaves (modes 0..3),
// driven by a bit-level SPI master and checked against word-level expectations.
module tb_spi_slave_xcvr;
  localparam int N = 5;
  localparam int H = 8;

`ifdef SPI_SLAVE_XCVR_FRAME_ERR_EN
  localparam int FERR_EXP = 1;
`else
  localparam int FERR_EXP = 0;
`endif

  function automatic int w_of(input int g);
    return (g == 0) ? 12 : 8;
  endfunction
  function automatic bit cpol_of(input int g);
    return (g == 0) ? 1'b0 : 1'(((g - 1) >> 1) & 1);
  endfunction
  function automatic bit cpha_of(input int g);
    return (g == 0) ? 1'b0 : 1'((g - 1) & 1);
  endfunction
  function automatic bit lsb_of(input int g);
    return (g == 0);
  endfunction
  function automatic logic [31:0] mask(input int g);
    return (32'h1 << w_of(g)) - 32'h1;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]       sclk_v, cs_v, mosi_v, miso_v;
  logic [N-1:0]       tx_valid_v, txr_v, rxv_v, ovr_v, ferr_v;
  logic [N-1:0][31:0] txd_v, rxd_v;
  logic               rx_rdy;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W  = w_of(g);
    spi_slave_xcvr_if #(.DATA_WIDTH(W)) bus ();
    assign bus.sclk     = sclk_v[g];
    assign bus.cs       = cs_v[g];
    assign bus.mosi     = mosi_v[g];
    assign bus.tx_data  = txd_v[g][W-1:0];
    assign bus.tx_valid = tx_valid_v[g];
    assign bus.rx_ready = rx_rdy;
    assign miso_v[g]    = bus.miso;
    assign txr_v[g]     = bus.tx_ready;
    assign rxd_v[g]     = 32'(bus.rx_data);
    assign rxv_v[g]     = bus.rx_valid;
    assign ovr_v[g]     = bus.overrun;
    assign ferr_v[g]    = bus.frame_err;

    spi_slave_xcvr #(
      .DATA_WIDTH (W),
      .CPOL       (cpol_of(g)),
      .CPHA       (cpha_of(g)),
      .LSB_FIRST  (lsb_of(g)),
      .SYNC_STAGES(2)
    ) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .io_spi(bus.slave)
    );
  end

  int errs = 0, checks = 0;
  int act = 0;

  // tx source fifo (written by stimulus, read by monitor) and rx log (reverse)
  logic [31:0] tx_buf[64];
  int          tx_wr = 0, tx_rd = 0;
  logic [31:0] rx_log[256];
  int          rx_n = 0, rx_rd = 0;
  int          txr_cnt[N], ovr_cnt[N], ferr_cnt[N];

  initial begin
    for (int g = 0; g < N; g++) begin
      txr_cnt[g] = 0; ovr_cnt[g] = 0; ferr_cnt[g] = 0;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (txr_v[g]) begin
        txr_cnt[g]++;
        if (g == act && tx_rd < tx_wr) tx_rd++;
      end
      if (ovr_v[g])  ovr_cnt[g]++;
      if (ferr_v[g]) ferr_cnt[g]++;
      if (rxv_v[g] && rx_rdy) begin
        rx_log[rx_n] = rxd_v[g];
        rx_n++;
      end
    end
    tx_valid_v = '0;
    txd_v      = '0;
    if (tx_rd < tx_wr) begin
      tx_valid_v[act] = 1'b1;
      txd_v[act]      = tx_buf[tx_rd];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #1 rx_rdy = v;
  endtask

  task automatic tx_push(input logic [31:0] v);
    tx_buf[tx_wr] = v;
    tx_wr++;
  endtask

  task automatic spi_begin(input int g);
    sclk_v[g] = cpol_of(g);
    cs_v[g]   = 1'b0;
  endtask

  task automatic spi_end(input int g);
    wait_clk(H);
    cs_v[g] = 1'b1;
    wait_clk(3 * H);
  endtask

  // One bit from the master's side: drive mosi, capture miso on the sample edge.
  task automatic spi_bit(input int g, input logic b, output logic m);
    logic pl;
    pl = cpol_of(g);
    if (!cpha_of(g)) begin
      mosi_v[g] = b;
      wait_clk(H);
      m = miso_v[g];
      sclk_v[g] = ~pl;
      wait_clk(H);
      sclk_v[g] = pl;
    end else begin
      wait_clk(H);
      mosi_v[g] = b;
      sclk_v[g] = ~pl;
      wait_clk(H);
      m = miso_v[g];
      sclk_v[g] = pl;
    end
  endtask

  task automatic spi_word(input int g, input logic [31:0] wd, output logic [31:0] rd);
    int w;
    logic m;
    w  = w_of(g);
    rd = '0;
    for (int k = 0; k < w; k++) begin
      int idx;
      idx = lsb_of(g) ? k : w - 1 - k;
      spi_bit(g, wd[idx], m);
      rd[idx] = m;
    end
  endtask

  task automatic run_frame(input int g, input int nw, input logic [31:0] w0, input logic [31:0] w1,
                           output logic [31:0] r0, output logic [31:0] r1);
    spi_begin(g);
    spi_word(g, w0, r0);
    r1 = '0;
    if (nw > 1) spi_word(g, w1, r1);
    spi_end(g);
  endtask

  // Frame of nw words with ntx queued tx words; master must see tx words then zeros.
  task automatic xfer_check(input int g, input int nw, input logic [31:0] w0, input logic [31:0] w1,
                            input int ntx, input logic [31:0] t0, input logic [31:0] t1);
    logic [31:0] r0, r1;
    int base_rx, base_txr;
    act = g;
    if (ntx >= 1) tx_push(t0);
    if (ntx >= 2) tx_push(t1);
    base_rx  = rx_n;
    base_txr = txr_cnt[g];
    run_frame(g, nw, w0, w1, r0, r1);
    chk($sformatf("g%0d_rx_count", g), rx_n - base_rx, nw);
    chk($sformatf("g%0d_rx0", g), rx_log[base_rx], w0);
    chk($sformatf("g%0d_miso0", g), r0, (ntx >= 1) ? t0 : 32'h0);
    if (nw > 1) begin
      chk($sformatf("g%0d_rx1", g), rx_log[base_rx + 1], w1);
      chk($sformatf("g%0d_miso1", g), r1, (ntx >= 2) ? t1 : 32'h0);
    end
    chk($sformatf("g%0d_tx_ready_count", g), txr_cnt[g] - base_txr, ntx);
    rx_rd = rx_n;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_miso"},      32'(miso_v[0]), 32'h0);
    chk({tag, "_tx_ready"},  32'(txr_v[0]),  32'h0);
    chk({tag, "_rx_data"},   rxd_v[0],       32'h0);
    chk({tag, "_rx_valid"},  32'(rxv_v[0]),  32'h0);
    chk({tag, "_overrun"},   32'(ovr_v[0]),  32'h0);
    chk({tag, "_frame_err"}, 32'(ferr_v[0]), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0, r1, w0, w1, part;
    logic m;
    int b_rx, b_ovr, b_ferr;

    rx_rdy = 1'b0;
    for (int g = 0; g < N; g++) begin
      sclk_v[g] = cpol_of(g);
      cs_v[g]   = 1'b1;
      mosi_v[g] = 1'b0;
    end
    wait_clk(6);
    chk_zero_outputs("reset");
    rst = 1'b0;
    wait_clk(6);

    // Plan word: rx_valid held while rx_ready is low, then drained.
    act = 0;
    tx_push(32'h3F1);
    b_rx = rx_n;
    run_frame(0, 1, 32'hA5C, 32'h0, r0, r1);
    chk("A_rx_data", rxd_v[0], 32'hA5C);
    chk("A_rx_valid", 32'(rxv_v[0]), 32'h1);
    chk("A_miso_word", r0, 32'h3F1);
    chk("A_tx_ready_count", txr_cnt[0], 32'd1);
    set_rdy(1'b1);
    wait_clk(4);
    chk("A_rx_logged", rx_n - b_rx, 32'd1);
    chk("A_rx_log", rx_log[b_rx], 32'hA5C);
    chk("A_rx_valid_cleared", 32'(rxv_v[0]), 32'h0);
    rx_rd = rx_n;

    // Overrun: two words with rx_ready low, first word kept.
    set_rdy(1'b0);
    w0 = $urandom & mask(0);
    w1 = $urandom & mask(0);
    b_ovr = ovr_cnt[0];
    b_rx  = rx_n;
    run_frame(0, 2, w0, w1, r0, r1);
    chk("C_rx_data_held", rxd_v[0], w0);
    chk("C_rx_valid", 32'(rxv_v[0]), 32'h1);
    chk("C_overrun_count", ovr_cnt[0] - b_ovr, 32'd1);
    set_rdy(1'b1);
    wait_clk(4);
    chk("C_rx_logged", rx_n - b_rx, 32'd1);
    chk("C_rx_log", rx_log[b_rx], w0);
    rx_rd = rx_n;

    // Partial frame (5 of 12 bits), then a clean 12'h001.
    b_ferr = ferr_cnt[0];
    b_rx   = rx_n;
    spi_begin(0);
    for (int k = 0; k < 5; k++) spi_bit(0, 1'($urandom_range(0, 1)), m);
    spi_end(0);
    chk("D_partial_no_rx", rx_n - b_rx, 32'd0);
    chk("D_partial_rx_valid", 32'(rxv_v[0]), 32'h0);
    xfer_check(0, 1, 32'h001, 32'h0, 0, 32'h0, 32'h0);
    chk("D_frame_err_count", ferr_cnt[0] - b_ferr, FERR_EXP);

    // Reset in the middle of a frame, released with cs still low.
    act = 0;
    tx_push(32'hFFF);
    b_rx   = rx_n;
    b_ferr = ferr_cnt[0];
    part   = '0;
    spi_begin(0);
    for (int k = 0; k < 5; k++) begin
      spi_bit(0, 1'b1, m);
      part[k] = m;
    end
    chk("E_miso_before_reset", part, 32'h1F);
    rst = 1'b1;
    wait_clk(3);
    chk_zero_outputs("E_in_reset");
    rst  = 1'b0;
    part = '0;
    for (int k = 0; k < 7; k++) begin
      spi_bit(0, 1'b1, m);
      part[k] = m;
    end
    chk("E_miso_ignored", part, 32'h0);
    spi_end(0);
    chk("E_ignored_no_rx", rx_n - b_rx, 32'd0);
    chk("E_ignored_rx_valid", 32'(rxv_v[0]), 32'h0);
    xfer_check(0, 1, 32'hFFF, 32'h0, 0, 32'h0, 32'h0);
    chk("E_frame_err_count", ferr_cnt[0] - b_ferr, 32'd0);

    // 8-bit MSB-first slaves in all four modes: plan words, then random traffic.
    for (int g = 1; g < N; g++) begin
      xfer_check(g, 2, 32'h81, 32'h7E, 0, 32'h0, 32'h0);
      for (int k = 0; k < 3; k++) begin
        int nw;
        nw = $urandom_range(1, 2);
        xfer_check(g, nw, $urandom & mask(g), $urandom & mask(g),
                   $urandom_range(0, nw), $urandom & mask(g), $urandom & mask(g));
      end
    end

    for (int k = 0; k < 3; k++) begin
      int nw;
      nw = $urandom_range(1, 2);
      xfer_check(0, nw, $urandom & mask(0), $urandom & mask(0),
                 $urandom_range(0, nw), $urandom & mask(0), $urandom & mask(0));
    end

    for (int g = 0; g < N; g++) chk($sformatf("g%0d_no_overrun_tail", g), 32'(ovr_v[g]), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
